sig_dump_ctrl: RTL and testbench

//  Hardware signature extractor for compliance runs. Waits for the test program's
//  end-of-test flag (RAM word 4 == 1), then reads ROM words in [begin_sig, end_sig)
//  and emits each one on a valid/ready stream. The stream feeds the UART TX

---
 rtl/sig_dump_ctrl_if.sv | 34 +++
 rtl/sig_dump_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sig_dump_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sig_dump_ctrl_if.sv
// Memory-read and signature-stream bundle for the signature dump controller.
// The master side issues ROM reads and drives the valid/ready/last stream.
interface sig_dump_ctrl_if #(
    parameter int unsigned MEM_AW = 12,
    parameter int unsigned DATA_W = 32
);
    logic              mem_rd_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [DATA_W-1:0] sig_data_o;
    logic              sig_valid_o;
    logic              sig_ready_i;
    logic              sig_last_o;

    modport master (
        output mem_rd_o,
        output mem_addr_o,
        input  mem_rdata_i,
        output sig_data_o,
        output sig_valid_o,
        input  sig_ready_i,
        output sig_last_o
    );

    modport slave (
        input  mem_rd_o,
        input  mem_addr_o,
        output mem_rdata_i,
        input  sig_data_o,
        input  sig_valid_o,
        output sig_ready_i,
        input  sig_last_o
    );
endinterface

// File: rtl/sig_dump_ctrl.sv
// Signature extractor: on a rising end-of-test flag, reads ROM words in
// [begin_sig, end_sig) one at a time and emits them on a valid/ready stream.
module sig_dump_ctrl #(
    parameter int unsigned MEM_AW = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           end_flag_i,
    input  logic [31:0]           begin_sig_i,
    input  logic [31:0]           end_sig_i,
    sig_dump_ctrl_if.master       bus,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned WORD_STEP = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE,
        S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic                flag_q, flag_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic                mem_rd_q, mem_rd_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   sig_data_q, sig_data_d;
    logic                sig_valid_q, sig_valid_d;
    logic                sig_last_q, sig_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                start_c;
    logic [ADDR_W-1:0]   cur_next_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            flag_q      <= 1'b0;
            cur_q       <= '0;
            end_q       <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            sig_data_q  <= '0;
            sig_valid_q <= 1'b0;
            sig_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flag_q      <= flag_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            sig_data_q  <= sig_data_d;
            sig_valid_q <= sig_valid_d;
            sig_last_q  <= sig_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the state being entered
    always_comb begin
        state_d     = state_q;
        flag_d      = (end_flag_i == 32'h1);
        cur_d       = cur_q;
        end_d       = end_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        sig_data_d  = sig_data_q;
        sig_valid_d = 1'b0;
        sig_last_d  = 1'b0;
        busy_d      = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        start_c     = flag_d & ~flag_q;
        cur_next_c  = ADDR_W'(cur_q + ADDR_W'(WORD_STEP));

        unique case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_CHECK;
                    cur_d   = begin_sig_i;
                    end_d   = end_sig_i;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_CHECK: begin
                if ((cur_q[1:0] != 2'b00) || (end_q[1:0] != 2'b00) || (cur_q > end_q)) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else if (cur_q == end_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // ROM data is valid exactly one cycle after the read strobe
                state_d     = S_SEND;
                sig_data_d  = bus.mem_rdata_i;
                sig_valid_d = 1'b1;
                sig_last_d  = (cur_next_c == end_q);
            end
            S_SEND: begin
                if (bus.sig_ready_i) begin
                    cur_d = cur_next_c;
                    if (sig_last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    sig_valid_d = 1'b1;
                    sig_last_d  = sig_last_q;
                end
            end
            S_DONE, S_ERR: begin
                if (!flag_d) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_READ) begin
            mem_rd_d   = 1'b1;
            mem_addr_d = cur_d[MEM_AW+1:2];
        end

        busy_d = (state_d == S_CHECK) || (state_d == S_READ) ||
                 (state_d == S_WAIT)  || (state_d == S_SEND);
    end

    assign bus.mem_rd_o    = mem_rd_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.sig_data_o  = sig_data_q;
    assign bus.sig_valid_o = sig_valid_q;
    assign bus.sig_last_o  = sig_last_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

    // Stream payload must not move while the consumer stalls
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (sig_valid_q && !bus.sig_ready_i) |=> (sig_valid_q && $stable(sig_data_q) && $stable(sig_last_q)));

    a_rd_single: assert property (@(posedge clk) disable iff (rst)
        mem_rd_q |=> !mem_rd_q);

    a_status_excl: assert property (@(posedge clk) disable iff (rst)
        !(busy_q && (done_q || err_q)));

endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Randomised self-checking bench for sig_dump_ctrl with a ROM model, a stream
// monitor and a list-based reference of the words each dump must produce.
module tb_sig_dump_ctrl;
    localparam int unsigned MEM_AW    = 12;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ROM_WORDS = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] end_flag  = 32'h0;
    logic [31:0] begin_sig = 32'h0;
    logic [31:0] end_sig   = 32'h0;
    logic        busy, done, err;

    int total = 0;
    int bad   = 0;

    sig_dump_ctrl_if #(.MEM_AW(MEM_AW), .DATA_W(DATA_W)) bus ();

    sig_dump_ctrl #(.MEM_AW(MEM_AW), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .end_flag_i  (end_flag),
        .begin_sig_i (begin_sig),
        .end_sig_i   (end_sig),
        .bus         (bus.master),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // ROM model: data valid one cycle after the strobe, garbage otherwise
    logic [31:0] rom [ROM_WORDS];
    always @(posedge clk) begin
        if (bus.mem_rd_o) bus.mem_rdata_i <= rom[bus.mem_addr_o];
        else              bus.mem_rdata_i <= $urandom;
    end

    // Ready generator: 0 tied high, 1 one-in-four, 2 high until one word taken, 3 coin flip
    int ready_mode = 0;
    int ready_base = 0;
    logic [31:0] got_data [$];
    logic        got_last [$];
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.sig_ready_i = 1'b1;
            1:       bus.sig_ready_i = ($urandom_range(0, 3) == 0);
            2:       bus.sig_ready_i = (got_data.size() < ready_base + 1);
            default: bus.sig_ready_i = $urandom_range(0, 1) == 1;
        endcase
    end

    // Stream monitor: records handshakes, counts reads/valids, flags stall instability
    int          rd_cnt = 0;
    int          valid_cnt = 0;
    int          stab_err = 0;
    logic        stall_p = 1'b0;
    logic [31:0] stall_d = 32'h0;
    logic        stall_l = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            stall_p = 1'b0;
        end else begin
            if (bus.mem_rd_o === 1'b1) rd_cnt++;
            if (bus.sig_valid_o === 1'b1) valid_cnt++;
            if (stall_p && !(bus.sig_valid_o === 1'b1 && bus.sig_data_o === stall_d &&
                             bus.sig_last_o === stall_l)) stab_err++;
            if (bus.sig_valid_o === 1'b1 && bus.sig_ready_i === 1'b1) begin
                got_data.push_back(bus.sig_data_o);
                got_last.push_back(bus.sig_last_o);
                stall_p = 1'b0;
            end else if (bus.sig_valid_o === 1'b1) begin
                stall_p = 1'b1;
                stall_d = bus.sig_data_o;
                stall_l = bus.sig_last_o;
            end else begin
                stall_p = 1'b0;
            end
        end
    end

    int base_q, base_rd, base_v, base_st;

    function automatic logic [31:0] rom_at(input logic [31:0] byte_addr);
        return rom[(byte_addr >> 2) % ROM_WORDS];
    endfunction

    task automatic snapshot();
        base_q  = got_data.size();
        base_rd = rd_cnt;
        base_v  = valid_cnt;
        base_st = stab_err;
    endtask

    // Raises the flag, scrambles the bound inputs while busy, waits for done/err, drops the flag
    task automatic run_dump(input logic [31:0] b, input logic [31:0] e, input int mode,
                            output int cyc, output bit timed_out);
        snapshot();
        ready_mode = mode;
        ready_base = got_data.size();
        @(negedge clk);
        begin_sig = b;
        end_sig   = e;
        end_flag  = 32'h1;
        cyc = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (done || err) begin
                timed_out = 1'b0;
                break;
            end
            if (i == 1) begin
                begin_sig = $urandom;
                end_sig   = $urandom;
            end
        end
        repeat (3) @(negedge clk);
        end_flag = 32'h0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if ({bus.sig_valid_o, bus.mem_rd_o, bus.sig_last_o} !== 3'b000) begin
            bad++; $display("FAIL reset_strobes got=%b want=000", {bus.sig_valid_o, bus.mem_rd_o, bus.sig_last_o}); end
        total++; if ({busy, done, err} !== 3'b000) begin
            bad++; $display("FAIL reset_status got=%b want=000", {busy, done, err}); end
        total++; if (bus.sig_data_o !== 32'h0 || bus.mem_addr_o !== 12'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h want=0/0", bus.sig_data_o, bus.mem_addr_o); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({busy, done, err, bus.sig_valid_o} !== 4'b0000) begin
            bad++; $display("FAIL idle_after_reset got=%b want=0000", {busy, done, err, bus.sig_valid_o}); end
    endtask

    task automatic test_basic();
        int cyc; bit to; int n;
        rom[12'h40] = 32'hA0A0_0001; rom[12'h41] = 32'hB0B0_0002; rom[12'h42] = 32'hC0C0_0003;
        run_dump(32'h100, 32'h10C, 0, cyc, to);
        n = got_data.size() - base_q;
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=timeout want=done"); end
        total++; if (n != 3) begin bad++; $display("FAIL basic_count got=%0d want=3", n); end
        for (int k = 0; k < 3 && k < n; k++) begin
            total++; if (got_data[base_q+k] !== rom[12'h40 + k]) begin
                bad++; $display("FAIL basic_data[%0d] got=%h want=%h", k, got_data[base_q+k], rom[12'h40 + k]); end
            total++; if (got_last[base_q+k] !== (k == 2)) begin
                bad++; $display("FAIL basic_last[%0d] got=%b want=%b", k, got_last[base_q+k], (k == 2)); end
        end
        total++; if (rd_cnt - base_rd != 3) begin bad++; $display("FAIL basic_reads got=%0d want=3", rd_cnt - base_rd); end
        total++; if ({done, err, busy} !== 3'b100) begin bad++; $display("FAIL basic_status got=%b want=100", {done, err, busy}); end
    endtask

    task automatic test_stall();
        int cyc; bit to; int n;
        run_dump(32'h100, 32'h10C, 1, cyc, to);
        n = got_data.size() - base_q;
        total++; if (to || n != 3) begin bad++; $display("FAIL stall_count got=%0d want=3", n); end
        for (int k = 0; k < 3 && k < n; k++) begin
            total++; if (got_data[base_q+k] !== rom[12'h40 + k] || got_last[base_q+k] !== (k == 2)) begin
                bad++; $display("FAIL stall_word[%0d] got=%h/%b want=%h/%b", k, got_data[base_q+k],
                                got_last[base_q+k], rom[12'h40 + k], (k == 2)); end
        end
        total++; if (stab_err - base_st != 0) begin bad++; $display("FAIL stall_stability got=%0d want=0", stab_err - base_st); end
        total++; if (rd_cnt - base_rd != 3) begin bad++; $display("FAIL stall_reads got=%0d want=3", rd_cnt - base_rd); end
    endtask

    task automatic test_empty();
        int cyc; bit to;
        run_dump(32'h200, 32'h200, 0, cyc, to);
        total++; if (to || cyc > 2) begin bad++; $display("FAIL empty_latency got=%0d want<=2", cyc); end
        total++; if (valid_cnt - base_v != 0 || rd_cnt - base_rd != 0) begin
            bad++; $display("FAIL empty_activity got=%0d/%0d want=0/0", valid_cnt - base_v, rd_cnt - base_rd); end
        total++; if ({done, err} !== 2'b10) begin bad++; $display("FAIL empty_status got=%b want=10", {done, err}); end
    endtask

    task automatic test_error();
        int cyc; bit to;
        logic [31:0] bs [2];
        logic [31:0] es [2];
        bs[0] = 32'h102; es[0] = 32'h10C;
        bs[1] = 32'h200; es[1] = 32'h100;
        for (int c = 0; c < 2; c++) begin
            run_dump(bs[c], es[c], 0, cyc, to);
            total++; if (to || {err, done} !== 2'b10) begin
                bad++; $display("FAIL err_status[%0d] got=%b want=10", c, {err, done}); end
            total++; if (rd_cnt - base_rd != 0 || valid_cnt - base_v != 0) begin
                bad++; $display("FAIL err_activity[%0d] got=%0d/%0d want=0/0", c, rd_cnt - base_rd, valid_cnt - base_v); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit to; int n; bit seen;
        snapshot();
        ready_mode = 2;
        ready_base = got_data.size();
        @(negedge clk);
        begin_sig = 32'h100; end_sig = 32'h10C; end_flag = 32'h1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (got_data.size() - base_q == 1 && bus.sig_valid_o === 1'b1) begin seen = 1'b1; break; end
        end
        total++; if (!seen) begin bad++; $display("FAIL midrst_reach_word2 got=timeout want=word2_valid"); end
        rst = 1'b1; end_flag = 32'h0;
        @(negedge clk);
        total++; if ({bus.sig_valid_o, bus.mem_rd_o, bus.sig_last_o, busy, done, err} !== 6'b0) begin
            bad++; $display("FAIL midrst_outputs got=%b want=000000",
                            {bus.sig_valid_o, bus.mem_rd_o, bus.sig_last_o, busy, done, err}); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (got_data.size() - base_q != 1 || rd_cnt - base_rd != 2) begin
            bad++; $display("FAIL midrst_quiet got=%0d/%0d want=1/2", got_data.size() - base_q, rd_cnt - base_rd); end
        run_dump(32'h100, 32'h10C, 0, cyc, to);
        n = got_data.size() - base_q;
        total++; if (to || n != 3) begin bad++; $display("FAIL midrst_redump_count got=%0d want=3", n); end
        for (int k = 0; k < 3 && k < n; k++) begin
            total++; if (got_data[base_q+k] !== rom[12'h40 + k]) begin
                bad++; $display("FAIL midrst_redump[%0d] got=%h want=%h", k, got_data[base_q+k], rom[12'h40 + k]); end
        end
    endtask

    task automatic test_hold();
        int b0; int r0; bit ok;
        snapshot();
        b0 = base_q; r0 = base_rd;
        ready_mode = 0;
        @(negedge clk);
        begin_sig = 32'h100; end_sig = 32'h10C; end_flag = 32'h1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin @(negedge clk); if (done) begin ok = 1'b1; break; end end
        repeat (40) @(negedge clk);
        total++; if (!ok || got_data.size() - b0 != 3 || rd_cnt - r0 != 3) begin
            bad++; $display("FAIL hold_no_retrigger got=%0d/%0d want=3/3", got_data.size() - b0, rd_cnt - r0); end
        end_flag = 32'h0;
        repeat (2) @(negedge clk);
        end_flag = 32'h1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin @(negedge clk); if (got_data.size() - b0 == 6 && done) begin ok = 1'b1; break; end end
        total++; if (!ok) begin bad++; $display("FAIL hold_second_dump got=%0d want=6", got_data.size() - b0); end
        for (int k = 0; k < 3 && got_data.size() - b0 >= 6; k++) begin
            total++; if (got_data[b0+3+k] !== got_data[b0+k] || got_data[b0+3+k] !== rom[12'h40 + k]) begin
                bad++; $display("FAIL hold_identical[%0d] got=%h want=%h", k, got_data[b0+3+k], rom[12'h40 + k]); end
        end
        end_flag = 32'h0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int cyc; bit to; int n; int kind; int mode; int len;
        logic [31:0] b, e, a;
        bit exp_err; int exp_n;
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 7);
            len  = $urandom_range(0, 6);
            b    = $urandom & 32'hFFFF_FFFC;
            case (kind)
                0: b = b | 32'($urandom_range(1, 3));
                1: len = -$urandom_range(1, 4);
                2: b = 32'h3FF8;
                default: ;
            endcase
            e = b + 32'(len * 4);
            mode = $urandom_range(0, 3);
            if (mode == 2) mode = 1;
            exp_err = (b[1:0] != 2'b00) || (e[1:0] != 2'b00) || (b > e);
            exp_n   = exp_err ? 0 : int'((e - b) >> 2);
            run_dump(b, e, mode, cyc, to);
            n = got_data.size() - base_q;
            total++; if (to || err !== exp_err || done !== !exp_err) begin
                bad++; $display("FAIL rand%0d_status b=%h e=%h got=%b%b want=%b%b", it, b, e, err, done, exp_err, !exp_err); end
            total++; if (n != exp_n || rd_cnt - base_rd != exp_n) begin
                bad++; $display("FAIL rand%0d_count b=%h e=%h got=%0d/%0d want=%0d", it, b, e, n, rd_cnt - base_rd, exp_n); end
            a = b;
            for (int k = 0; k < exp_n && k < n; k++) begin
                total++; if (got_data[base_q+k] !== rom_at(a) || got_last[base_q+k] !== (k == exp_n - 1)) begin
                    bad++; $display("FAIL rand%0d_word[%0d] got=%h/%b want=%h/%b", it, k, got_data[base_q+k],
                                    got_last[base_q+k], rom_at(a), (k == exp_n - 1)); end
                a = a + 32'd4;
            end
            total++; if (stab_err - base_st != 0) begin bad++; $display("FAIL rand%0d_stability got=%0d want=0", it, stab_err - base_st); end
        end
    endtask

    initial begin
        for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] = $urandom;
        bus.sig_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_empty();
        test_error();
        test_reset_mid();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
